param_alu: RTL
==============

// Module: param_alu
// PURPOSE
//  Parametrised, handshaked successor of the single-cycle ALU: unsigned ADD/SUB/MUL/DIV/MOD/ACC/MAC on WIDTH-bit operands.
//  valid/ready on input and output. Accumulator persists across ops. Iterative divider (1 quotient bit/cycle).
//  Reports overflow and divide-by-zero. Sits between the stimulus driver and the scoreboard in the ALU test bench.
// PARAMETERS
//  WIDTH      32  operand/result width in bits (>=4)
//  ACC_INIT    0  accumulator value after reset and after acc_clr
// PORTS
//  clock        in   1      single clock, all logic on posedge
//  reset        in   1      synchronous, active-high reset
//  in_valid     in   1      operand/opcode valid
//  in_ready     out  1      block can accept (high only in IDLE)
//  a            in   WIDTH  operand A (unsigned)
//  b            in   WIDTH  operand B (unsigned)
//  mode_select  in   opcode operation select (tb_pkg::opcode)
//  acc_clr      in   1      clear accumulator to ACC_INIT
//  out_valid    out  1      result valid; held until out_ready
//  out_ready    in   1      consumer accepts result
//  c            out  WIDTH  result
//  ovf          out  1      carry/borrow/overflow of this result
//  dbz          out  1      divide-by-zero on DIV/MOD
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=0 during reset then 1. out_valid/c/ovf/dbz=0. acc_q=ACC_INIT. Divider aborted.
//  Reset wins over every other input and aborts any op mid-flight. The result is discarded.
//  FSM IDLE -> (accept, non-DIV/MOD) -> DONE. IDLE -> (accept, DIV/MOD, b!=0) -> DIVIDE. DIVIDE -> (div_done) -> DONE.
//   DONE -> (out_ready) -> IDLE.
//  Accept = in_valid && in_ready. a, b and mode_select are captured only on accept.
//  Latency: non-DIV/MOD ops: accept at cycle N, out_valid at N+1.
//   DIV/MOD with b!=0: out_valid at N+WIDTH+1. DIV/MOD with b==0: out_valid at N+1.
//  Output hold: in DONE, c/ovf/dbz are stable while out_valid && !out_ready.
//   out_valid drops the cycle after out_ready. No new accept before returning to IDLE (no bypass).
//  Arithmetic is unsigned, all results truncated to WIDTH bits. ovf is defined per op:
//   ADD: carry out of bit WIDTH-1. SUB: borrow (a<b). MUL: nonzero high half of the 2*WIDTH product.
//   ACC: acc_base+a carries. MAC: acc_base+a*b exceeds 2^WIDTH-1. DIV/MOD: ovf=0.
//  DIV/MOD with b==0: c=all-ones (DIV) or a (MOD), dbz=1, divider not started.
//  Accumulator: acc_base = acc_clr ? ACC_INIT : acc_q, evaluated in the accept cycle.
//   ACC/MAC accept: acc_q <= result, c = result. Other ops leave acc_q unchanged.
//   acc_clr with no ACC/MAC accept that cycle: acc_q <= ACC_INIT.
//  Opcode values outside the defined enum: c=0, ovf=0, dbz=0, latency 1, acc_q unchanged.
// CONFIGURATION
//  ALU_SAT_EN defined: saturation is active. When ovf=1, ADD/MUL/ACC/MAC give all-ones and SUB gives 0.
//   acc_q stores the saturated value. ovf is still reported.
//  ALU_SAT_EN undefined: results wrap modulo 2^WIDTH. ovf is reported identically.
// STRUCTURE
//  Package: opcode stays in tb_pkg. Add to tb_pkg:
//   alu_state_t enum {IDLE, DIVIDE, DONE}
//   function alu_model(a,b,op,acc,width) returning {c,ovf,dbz}, for bench use.
//  Sub-module alu_divider #(WIDTH): restoring divider.
//   Ports: clock, reset, start, dividend, divisor, done, quotient, remainder.
//   done is a 1-cycle pulse exactly WIDTH cycles after start.
// TESTING (WIDTH=32)
//  ADD a=0xFFFF_FFFF, b=2, out_ready=1 -> 1 cycle later c=0x1, ovf=1 (wrap) or c=0xFFFF_FFFF (ALU_SAT_EN).
//  DIV a=100, b=7 -> in_ready=0 for 33 cycles, out_valid at N+33, c=14. MOD on same operands -> c=2.
//  DIV a=5, b=0 -> out_valid at N+1, c=0xFFFF_FFFF, dbz=1. MOD a=5, b=0 -> c=5, dbz=1.
//  acc_clr, then ACC a=10, then MAC a=3 b=4 -> c=10, then c=22. acc_clr+ACC a=7 in same cycle -> c=7.
//  Backpressure: out_ready=0 for 5 cycles after MUL 0x1_0000*0x1_0000 -> c=0, ovf=1 held stable, in_ready=0.
//   Then out_ready=1 -> IDLE next cycle.
//  reset asserted at cycle 10 of a DIV -> next cycle out_valid=0, in_ready=1, acc_q=0. Following ADD 1+1 -> c=2.

Source files
------------

// File: rtl/tb_pkg.sv
// rtl/tb_pkg.sv - shared ALU opcodes, FSM states and reference model (ALU_SAT_EN selects saturation)
package tb_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_MOD = 3'd4,
        OP_ACC = 3'd5,
        OP_MAC = 3'd6
    } opcode;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic [63:0] c;
        logic        ovf;
        logic        dbz;
    } alu_result_t;

    // Reference model for bench use; valid for width 1..32 so products fit in 64 bits.
    function automatic alu_result_t alu_model(input logic [63:0] a,
                                              input logic [63:0] b,
                                              input opcode       op,
                                              input logic [63:0] acc,
                                              input int unsigned width);
        alu_result_t r;
        logic [63:0] mask;
        logic [63:0] aa;
        logic [63:0] bb;
        logic [63:0] ac;
        logic [63:0] full;
        r    = '0;
        mask = (64'd1 << width) - 64'd1;
        aa   = a & mask;
        bb   = b & mask;
        ac   = acc & mask;
        full = '0;
        case (op)
            OP_ADD: begin full = aa + bb;      r.ovf = |(full & ~mask); end
            OP_SUB: begin full = aa - bb;      r.ovf = (aa < bb);       end
            OP_MUL: begin full = aa * bb;      r.ovf = |(full & ~mask); end
            OP_ACC: begin full = ac + aa;      r.ovf = |(full & ~mask); end
            OP_MAC: begin full = ac + aa * bb; r.ovf = |(full & ~mask); end
            OP_DIV: begin
                if (bb == 64'd0) begin full = mask; r.dbz = 1'b1; end
                else             full = aa / bb;
            end
            OP_MOD: begin
                if (bb == 64'd0) begin full = aa; r.dbz = 1'b1; end
                else             full = aa % bb;
            end
            default: full = '0;
        endcase
        r.c = full & mask;
`ifdef ALU_SAT_EN
        if (r.ovf) r.c = (op == OP_SUB) ? 64'd0 : mask;
`endif
        return r;
    endfunction

endpackage

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - restoring divider, one quotient bit per cycle, done pulses WIDTH cycles after start
module alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                    input logic [WIDTH-1:0] q,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] diff;
        sh   = {r, q[WIDTH-1]};
        diff = sh - {1'b0, d};
        if (diff[WIDTH]) return {sh[WIDTH-1:0],   q[WIDTH-2:0], 1'b0};
        else             return {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
    endfunction

    // The first step is taken on the start edge so the last one lands WIDTH cycles later.
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            {rem_d, quo_d} = div_step('0, dividend, divisor);
            div_d  = divisor;
            cnt_d  = CW'(1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, div_q);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Divider state; reset aborts any division in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/param_alu.sv
// rtl/param_alu.sv - handshaked unsigned ALU with accumulator and iterative divider (ALU_SAT_EN selects saturation)
module param_alu
    import tb_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode            mode_select,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             ovf,
    output logic             dbz
);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;
    logic             out_valid_q, out_valid_d;
    logic             is_mod_q, is_mod_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             accept;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    logic [WIDTH-1:0]   acc_base;
    logic [WIDTH:0]     add_full;
    logic [WIDTH:0]     sub_full;
    logic [WIDTH:0]     acc_full;
    logic [2*WIDTH-1:0] mul_full;
    logic [2*WIDTH:0]   mac_full;
    logic [WIDTH-1:0]   res_c;
    logic               res_ovf;
    logic               res_dbz;

    assign in_ready = (state_q == IDLE) && !reset;
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath evaluated on the live inputs; only used in the accept cycle.
    always_comb begin
        acc_base = acc_clr ? ACC_INIT : acc_q;
        add_full = {1'b0, a} + {1'b0, b};
        sub_full = {1'b0, a} - {1'b0, b};
        acc_full = {1'b0, acc_base} + {1'b0, a};
        mul_full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        mac_full = {{(WIDTH+1){1'b0}}, acc_base} + {1'b0, mul_full};
        res_c    = '0;
        res_ovf  = 1'b0;
        res_dbz  = 1'b0;
        case (mode_select)
            OP_ADD: begin res_c = add_full[WIDTH-1:0]; res_ovf = add_full[WIDTH];             end
            OP_SUB: begin res_c = sub_full[WIDTH-1:0]; res_ovf = sub_full[WIDTH];             end
            OP_MUL: begin res_c = mul_full[WIDTH-1:0]; res_ovf = |mul_full[2*WIDTH-1:WIDTH]; end
            OP_ACC: begin res_c = acc_full[WIDTH-1:0]; res_ovf = acc_full[WIDTH];             end
            OP_MAC: begin res_c = mac_full[WIDTH-1:0]; res_ovf = |mac_full[2*WIDTH:WIDTH];   end
            OP_DIV: begin res_c = '1; res_dbz = (b == '0); end
            OP_MOD: begin res_c = a;  res_dbz = (b == '0); end
            default: ;
        endcase
`ifdef ALU_SAT_EN
        if (res_ovf) res_c = (mode_select == OP_SUB) ? '0 : '1;
`endif
    end

    // Control FSM plus accumulator and output-register next state.
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        is_mod_d    = is_mod_q;
        div_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if ((mode_select == OP_DIV || mode_select == OP_MOD) && b != '0) begin
                        div_start = 1'b1;
                        is_mod_d  = (mode_select == OP_MOD);
                        state_d   = DIVIDE;
                    end else begin
                        c_d         = res_c;
                        ovf_d       = res_ovf;
                        dbz_d       = res_dbz;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    c_d         = is_mod_q ? div_rem : div_quo;
                    ovf_d       = 1'b0;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        acc_d = acc_q;
        if (accept && (mode_select == OP_ACC || mode_select == OP_MAC)) acc_d = res_c;
        else if (acc_clr)                                               acc_d = ACC_INIT;
    end

    // State and registered outputs; reset discards any result in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            c_q         <= '0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
            is_mod_q    <= 1'b0;
            acc_q       <= ACC_INIT;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
            is_mod_q    <= is_mod_d;
            acc_q       <= acc_d;
        end
    end

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .clock     (clock),
        .reset     (reset),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule
